coin_hopper_ctrl: RTL and testbench



---
 rtl/coin_hopper_ctrl.sv | 146 ++++++++++++++
 tb/tb_coin_hopper_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_hopper_ctrl.sv
// Coin hopper payout controller: queues payout requests, runs the motor
// one coin at a time, confirms via exit sensor, detects jams, spaces coins.
// Ports: clk, clrb (async active-low), coin_out/coin_sense/jam_clr in;
// motor, busy, pending[CNT_W], jam, ovf, paid_cnt[8] out.
// Optional macro HOPPER_STAT_EN enables the paid_cnt delivery counter.
module coin_hopper_ctrl #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             coin_out,
  input  logic             coin_sense,
  input  logic             jam_clr,
  output logic             motor,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             jam,
  output logic             ovf,
  output logic [7:0]       paid_cnt
);

  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    G_LAST = TW'(GAP - 1);
  localparam logic [CNT_W-1:0] P_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_JAM
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             co_q, cs_q;
  logic             req_e, sns_e, acc;

  assign req_e = coin_out & ~co_q;
  assign sns_e = coin_sense & ~cs_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_RUN;
          timer_d = '0;
        end
      end
      S_RUN: begin
        // a sensor edge on the last allowed cycle still counts as a coin
        if (sns_e) begin
          acc     = 1'b1;
          state_d = S_GAP;
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          state_d = S_JAM;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q == G_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_JAM: begin
        if (jam_clr) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (jam_clr) ovf_d = 1'b0;
    // request and delivery in one cycle cancel out
    unique case (1'b1)
      (req_e & ~acc & (pend_q == P_MAX)): ovf_d  = 1'b1;
      (req_e & ~acc & (pend_q != P_MAX)): pend_d = pend_q + CNT_W'(1);
      (acc & ~req_e):                     pend_d = pend_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      co_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      co_q    <= coin_out;
      cs_q    <= coin_sense;
    end
  end

`ifdef HOPPER_STAT_EN
  logic [7:0] paid_q;

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      paid_q <= '0;
    end else if (acc) begin
      paid_q <= paid_q + 8'd1;
    end
  end

  assign paid_cnt = paid_q;
`else
  assign paid_cnt = 8'd0;
`endif

  assign motor   = (state_q == S_RUN);
  assign jam     = (state_q == S_JAM);
  assign busy    = (state_q != S_IDLE) | (pend_q != '0);
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_coin_hopper_ctrl.sv
// Bench for coin_hopper_ctrl: vector table, corner sequences and
// random stimulus checked against a timestamp-based reference model.
module tb_coin_hopper_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;
  localparam int PMAX    = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_GAP  = 2;
  localparam int M_JAM  = 3;

  logic             clk = 1'b0;
  logic             clrb;
  logic             coin_out;
  logic             coin_sense;
  logic             jam_clr;
  logic             motor;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             jam;
  logic             ovf;
  logic [7:0]       paid_cnt;

  coin_hopper_ctrl #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .GAP    (GAP)
  ) dut (
    .clk       (clk),
    .clrb      (clrb),
    .coin_out  (coin_out),
    .coin_sense(coin_sense),
    .jam_clr   (jam_clr),
    .motor     (motor),
    .busy      (busy),
    .pending   (pending),
    .jam       (jam),
    .ovf       (ovf),
    .paid_cnt  (paid_cnt)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int m_mode, m_enter, m_pend, m_paid;
  bit m_ovf, m_co, m_cs;

  typedef struct {
    bit co;
    bit cs;
    bit jc;
    bit motor;
    bit busy;
    int pend;
    bit jam;
    bit ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_enter = cyc;
    m_pend  = 0;
    m_paid  = 0;
    m_ovf   = 0;
    m_co    = 0;
    m_cs    = 0;
  endtask

  task automatic model_chk();
    int exp_paid;
`ifdef HOPPER_STAT_EN
    exp_paid = m_paid;
`else
    exp_paid = 0;
`endif
    chk("m_motor", {31'd0, motor}, (m_mode == M_RUN) ? 1 : 0);
    chk("m_jam", {31'd0, jam}, (m_mode == M_JAM) ? 1 : 0);
    chk("m_busy", {31'd0, busy},
        (m_mode != M_IDLE || m_pend != 0) ? 1 : 0);
    chk("m_pending", {28'd0, pending}, m_pend);
    chk("m_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("m_paid", {24'd0, paid_cnt}, exp_paid);
  endtask

  // one clock: predict from the inputs presented now, then compare
  task automatic tick();
    bit re, se, acc, drop, co, cs, jc;
    int el, nmode, npend;
    co    = coin_out;
    cs    = coin_sense;
    jc    = jam_clr;
    re    = co && !m_co;
    se    = cs && !m_cs;
    el    = cyc - m_enter;
    acc   = (m_mode == M_RUN) && se;
    npend = m_pend;
    drop  = 0;
    if (re && !acc) begin
      if (m_pend == PMAX) drop = 1;
      else npend = m_pend + 1;
    end else if (acc && !re) begin
      npend = m_pend - 1;
    end
    nmode = m_mode;
    case (m_mode)
      M_IDLE: if (m_pend > 0) nmode = M_RUN;
      M_RUN: begin
        if (se) nmode = M_GAP;
        else if (el + 1 >= TIMEOUT) nmode = M_JAM;
      end
      M_GAP: if (el + 1 >= GAP) nmode = M_IDLE;
      M_JAM: if (jc) nmode = M_IDLE;
      default: nmode = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    if (!clrb) begin
      model_reset();
    end else begin
      if (jc) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (acc) m_paid = (m_paid + 1) % 256;
      m_pend = npend;
      m_co   = co;
      m_cs   = cs;
      if (nmode != m_mode) begin
        m_mode  = nmode;
        m_enter = cyc + 1;
      end
    end
    cyc++;
    model_chk();
  endtask

  task automatic pulse();
    coin_out = 1'b1;
    tick();
    coin_out = 1'b0;
    tick();
  endtask

  task automatic sync_reset();
    clrb = 1'b0;
    coin_out = 1'b0;
    coin_sense = 1'b0;
    jam_clr = 1'b0;
    tick();
    clrb = 1'b1;
    tick();
  endtask

  initial begin
    int n, rises, on_cnt, low_run, min_gap;
    bit prev;

    clrb = 1'b0;
    coin_out = 1'b0;
    coin_sense = 1'b0;
    jam_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_motor", {31'd0, motor}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_pending", {28'd0, pending}, 0);
    chk("rst_jam", {31'd0, jam}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_paid", {24'd0, paid_cnt}, 0);
    clrb = 1'b1;

    // single payout, cycle by cycle
    tbl[0] = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 1, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 1, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      coin_out   = tbl[i].co;
      coin_sense = tbl[i].cs;
      jam_clr    = tbl[i].jc;
      tick();
      chk($sformatf("tbl%0d_motor", i), {31'd0, motor},
          {31'd0, tbl[i].motor});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy},
          {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_pend", i), {28'd0, pending}, tbl[i].pend);
      chk($sformatf("tbl%0d_jam", i), {31'd0, jam},
          {31'd0, tbl[i].jam});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf},
          {31'd0, tbl[i].ovf});
    end
`ifdef HOPPER_STAT_EN
    chk("single_paid", {24'd0, paid_cnt}, 1);
`endif
    coin_sense = 1'b0;

    // jam: motor on for exactly TIMEOUT cycles
    sync_reset();
    pulse();
    chk("jam_motor_on", {31'd0, motor}, 1);
    n = 0;
    while (motor === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("jam_motor_cycles", n, TIMEOUT);
    chk("jam_flag", {31'd0, jam}, 1);
    chk("jam_pending", {28'd0, pending}, 1);
    jam_clr = 1'b1;
    tick();
    jam_clr = 1'b0;
    chk("jamclr_jam", {31'd0, jam}, 0);
    chk("jamclr_idle", {31'd0, motor}, 0);
    tick();
    chk("jamclr_rerun", {31'd0, motor}, 1);

    // saturation
    sync_reset();
    repeat (PMAX + 1) pulse();
    chk("sat_pending", {28'd0, pending}, PMAX);
    chk("sat_ovf", {31'd0, ovf}, 1);
    jam_clr = 1'b1;
    tick();
    jam_clr = 1'b0;
    chk("sat_ovf_clr", {31'd0, ovf}, 0);
    chk("sat_pend_kept", {28'd0, pending}, PMAX);

    // request and sense in the same RUN cycle
    sync_reset();
    pulse();
    pulse();
    chk("simul_pre", {28'd0, pending}, 2);
    coin_out = 1'b1;
    coin_sense = 1'b1;
    tick();
    coin_out = 1'b0;
    coin_sense = 1'b0;
    chk("simul_pending", {28'd0, pending}, 2);
    chk("simul_motor", {31'd0, motor}, 0);

    // sense on the timeout cycle wins
    sync_reset();
    pulse();
    repeat (TIMEOUT - 1) tick();
    chk("tmo_still_run", {31'd0, motor}, 1);
    coin_sense = 1'b1;
    tick();
    coin_sense = 1'b0;
    chk("tmo_no_jam", {31'd0, jam}, 0);
    chk("tmo_pending", {28'd0, pending}, 0);

    // burst of three, answer each coin on its 3rd motor cycle
    sync_reset();
    rises = 0;
    on_cnt = 0;
    low_run = 0;
    min_gap = 999;
    prev = 0;
    for (int i = 0; i < 70; i++) begin
      coin_out = (i < 6) && (i % 2 == 0);
      coin_sense = (on_cnt == 3);
      tick();
      if (motor === 1'b1) begin
        if (!prev) begin
          rises++;
          if (rises > 1 && low_run < min_gap) min_gap = low_run;
          on_cnt = 0;
        end
        on_cnt++;
        low_run = 0;
        prev = 1;
      end else begin
        on_cnt = 0;
        low_run++;
        prev = 0;
      end
    end
    coin_out = 1'b0;
    coin_sense = 1'b0;
    chk("burst_intervals", rises, 3);
    chk("burst_gap_ok", (min_gap >= GAP + 1) ? 1 : 0, 1);
    chk("burst_pending", {28'd0, pending}, 0);

    // async reset in the middle of RUN
    sync_reset();
    repeat (3) pulse();
    chk("arst_pre_pend", {28'd0, pending}, 3);
    chk("arst_pre_motor", {31'd0, motor}, 1);
    #2;
    clrb = 1'b0;
    #1;
    chk("arst_motor", {31'd0, motor}, 0);
    chk("arst_pending", {28'd0, pending}, 0);
    chk("arst_jam", {31'd0, jam}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    tick();
    clrb = 1'b1;
    tick();
    chk("arst_idle", {31'd0, motor}, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      coin_out = ($urandom % 3 == 0);
      coin_sense = ($urandom % 4 == 0);
      jam_clr = ($urandom % 40 == 0);
      tick();
    end
    coin_out = 1'b0;
    coin_sense = 1'b0;
    jam_clr = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
